// File: rtl/imem_load_fetch_ctrl.sv
// Loader/fetch sequencer that owns the 256x16 instruction memory.
// Optional KEY_DEBOUNCE_EN adds a per-key debounce counter after the synchronizer.

module imem_key_pulse #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic pulse
);
  logic [1:0] sync;
  logic       lvl;
  logic       lvl_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= '0;
    else        sync <= {sync[0], key};
  end

`ifdef KEY_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [CW-1:0] cnt;
  logic          deb;

  // The level only moves once the synchronized key has disagreed for the full window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      deb <= 1'b0;
    end else if (sync[1] == deb) begin
      cnt <= '0;
    end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      cnt <= '0;
      deb <= sync[1];
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
  assign lvl = deb;
`else
  assign lvl = sync[1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lvl_q <= 1'b0;
    else        lvl_q <= lvl;
  end

  assign pulse = lvl & ~lvl_q;
endmodule

module imem_load_fetch_ctrl #(
  parameter int              ADDR_W          = 8,
  parameter int              DATA_W          = 16,
  parameter logic [DATA_W-1:0] HALT_WORD     = 16'hFFFF,
  parameter int              DEBOUNCE_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] dip,
  input  logic              key_write,
  input  logic              key_run,
  input  logic              key_load,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] disp_addr,
  output logic [1:0]        mode,
  output logic              wrapped
);
  localparam int NUM_KEYS = 3;
  localparam int K_WR     = 0;
  localparam int K_RUN    = 1;
  localparam int K_LD     = 2;

  typedef enum logic [2:0] {
    S_LOAD, S_WRITE, S_FETCH, S_WAIT, S_VALID, S_HALT
  } state_t;

  logic [NUM_KEYS-1:0] keys;
  logic [NUM_KEYS-1:0] pulses;
  logic                p_wr, p_run, p_ld;

  assign keys  = {key_load, key_run, key_write};
  assign p_wr  = pulses[K_WR];
  assign p_run = pulses[K_RUN];
  assign p_ld  = pulses[K_LD];

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    imem_key_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
      .clk   (clk),
      .rst_n (rst_n),
      .key   (keys[k]),
      .pulse (pulses[k])
    );
  end

  state_t              state, state_n;
  logic [ADDR_W-1:0]   load_ptr, load_ptr_n;
  logic [ADDR_W-1:0]   pc_n;
  logic [DATA_W-1:0]   wdata, wdata_n;
  logic [DATA_W-1:0]   instr_n;
  logic                valid_n;
  logic                wrapped_n;
  logic [ADDR_W-1:0]   addr_n;
  logic [DATA_W-1:0]   din_n;
  logic                we_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_LOAD;
      load_ptr    <= '0;
      pc          <= '0;
      wdata       <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      wrapped     <= 1'b0;
      mem_addr    <= '0;
      mem_din     <= '0;
      mem_we      <= 1'b0;
    end else begin
      state       <= state_n;
      load_ptr    <= load_ptr_n;
      pc          <= pc_n;
      wdata       <= wdata_n;
      instr       <= instr_n;
      instr_valid <= valid_n;
      wrapped     <= wrapped_n;
      mem_addr    <= addr_n;
      mem_din     <= din_n;
      mem_we      <= we_n;
    end
  end

  always_comb begin
    state_n    = state;
    load_ptr_n = load_ptr;
    pc_n       = pc;
    wdata_n    = wdata;
    instr_n    = instr;
    valid_n    = instr_valid;
    wrapped_n  = wrapped;
    case (state)
      S_LOAD: begin
        // Write outranks run; a simultaneous run pulse is simply dropped.
        if (p_wr) begin
          state_n = S_WRITE;
          wdata_n = dip;
        end else if (p_run) begin
          state_n = S_FETCH;
          pc_n    = '0;
        end else if (p_ld) begin
          load_ptr_n = '0;
          wrapped_n  = 1'b0;
        end
      end
      S_WRITE: begin
        load_ptr_n = load_ptr + 1'b1;
        if (load_ptr == '1) wrapped_n = 1'b1;
        state_n = S_LOAD;
      end
      S_FETCH, S_WAIT, S_VALID: begin
        // Abort beats any handshake completing in the same cycle.
        if (p_ld) begin
          state_n    = S_LOAD;
          valid_n    = 1'b0;
          pc_n       = '0;
          load_ptr_n = '0;
          wrapped_n  = 1'b0;
        end else if (state == S_FETCH) begin
          state_n = S_WAIT;
        end else if (state == S_WAIT) begin
          if (mem_dout == HALT_WORD) begin
            state_n = S_HALT;
          end else begin
            instr_n = mem_dout;
            valid_n = 1'b1;
            state_n = S_VALID;
          end
        end else if (instr_ready) begin
          valid_n = 1'b0;
          if (pc == '1) begin
            state_n = S_HALT;
          end else begin
            pc_n    = pc + 1'b1;
            state_n = S_FETCH;
          end
        end
      end
      S_HALT: begin
        if (p_ld) begin
          state_n    = S_LOAD;
          load_ptr_n = '0;
          wrapped_n  = 1'b0;
        end else if (p_run) begin
          state_n = S_FETCH;
          pc_n    = '0;
        end
      end
      default: state_n = S_LOAD;
    endcase
  end

  // Memory port is registered from next-state values so it lines up with the state.
  always_comb begin
    we_n   = (state_n == S_WRITE);
    din_n  = we_n ? wdata_n : mem_din;
    addr_n = (state_n == S_LOAD || state_n == S_WRITE) ? load_ptr_n : pc_n;
  end

  always_comb begin
    case (state)
      S_LOAD, S_WRITE:          mode = 2'b00;
      S_FETCH, S_WAIT, S_VALID: mode = 2'b01;
      S_HALT:                   mode = 2'b10;
      default:                  mode = 2'b00;
    endcase
  end

  assign disp_addr = (state == S_LOAD || state == S_WRITE) ? load_ptr : pc;
endmodule

// File: tb/tb_imem_load_fetch_ctrl.sv
// Self-checking bench: vector table for loads, scoreboards for memory writes and fetched words.
module tb_imem_load_fetch_ctrl;
  localparam int AW = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] dip = '0;
  logic [2:0]    keys = '0;   // {load, run, write}
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic          mem_we;
  logic [DW-1:0] mem_dout;
  logic [DW-1:0] instr;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic [AW-1:0] pc;
  logic [AW-1:0] disp_addr;
  logic [1:0]    mode;
  logic          wrapped;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0]    mem [0:255];
  logic [DW-1:0]    iq [$];
  logic [AW+DW-1:0] wq [$];

  typedef struct {
    logic [DW-1:0] dip;
    logic [AW-1:0] exp_addr;
    logic [AW-1:0] exp_disp;
  } vec_t;
  vec_t vecs [3];

  always #5 clk = ~clk;

  imem_load_fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .dip(dip),
    .key_write(keys[0]), .key_run(keys[1]), .key_load(keys[2]),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .pc(pc), .disp_addr(disp_addr), .mode(mode), .wrapped(wrapped)
  );

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_din;
    mem_dout <= mem[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      chk("write_expected", 32'(wq.size() > 0), 32'd1);
      if (wq.size() > 0) chk("write_addr_data", 32'({mem_addr, mem_din}), 32'(wq.pop_front()));
    end
    if (rst_n && instr_valid && instr_ready) begin
      chk("instr_expected", 32'(iq.size() > 0), 32'd1);
      if (iq.size() > 0) chk("instr_value", 32'(instr), 32'(iq.pop_front()));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_key(input int k);
    step();
    keys[k] = 1'b1;
    repeat (5) step();
    keys[k] = 1'b0;
    repeat (4) step();
  endtask

  task automatic load_word(input logic [DW-1:0] d, input logic [AW-1:0] a);
    dip = d;
    wq.push_back({a, d});
    pulse_key(0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1);
  end

  initial begin
    bit found;
    vecs[0] = '{dip: 16'h1234, exp_addr: 8'd0, exp_disp: 8'd1};
    vecs[1] = '{dip: 16'hABCD, exp_addr: 8'd1, exp_disp: 8'd2};
    vecs[2] = '{dip: 16'h0F0F, exp_addr: 8'd2, exp_disp: 8'd3};

    #2;
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_outputs", 32'({mem_addr, instr_valid, pc, disp_addr, mode, wrapped}), 0);
    step();
    rst_n = 1'b1;
    repeat (2) step();

    foreach (vecs[i]) begin
      load_word(vecs[i].dip, vecs[i].exp_addr);
      chk("load_disp", 32'(disp_addr), 32'(vecs[i].exp_disp));
      chk("load_mode", 32'(mode), 0);
    end

    // write and run together: only the write happens
    dip = 16'h5555;
    wq.push_back({8'd3, 16'h5555});
    step();
    keys[0] = 1'b1;
    keys[1] = 1'b1;
    repeat (8) begin
      step();
      chk("wr_run_mode", 32'(mode), 0);
    end
    keys = '0;
    repeat (4) step();
    chk("wr_run_disp", 32'(disp_addr), 4);

    pulse_key(2);
    chk("load_ptr_clear", 32'(disp_addr), 0);
    load_word(16'h0001, 8'd0);
    load_word(16'h0002, 8'd1);
    load_word(16'hFFFF, 8'd2);
    chk("preload_disp", 32'(disp_addr), 3);

    // run with backpressure
    instr_ready = 1'b0;
    iq.push_back(16'h0001);
    iq.push_back(16'h0002);
    pulse_key(1);
    chk("bp_valid", 32'(instr_valid), 1);
    chk("bp_mode", 32'(mode), 1);
    repeat (10) begin
      step();
      chk("bp_hold", 32'({instr_valid, instr, pc, mem_addr}), 32'({1'b1, 16'h0001, 8'd0, 8'd0}));
    end
    instr_ready = 1'b1;
    step();
    chk("bp_pc_next", 32'(pc), 1);
    for (int i = 0; i < 30 && mode != 2'b10; i++) step();
    chk("halt_mode", 32'(mode), 2);
    chk("halt_pc", 32'(pc), 2);
    chk("halt_no_valid", 32'(instr_valid), 0);
    chk("run_q_empty", 32'(iq.size()), 0);

    // abort concurrent with handshake
    instr_ready = 1'b0;
    iq.push_back(16'h0001);
    pulse_key(1);
    chk("abort_pre_valid", 32'({instr_valid, instr}), 32'({1'b1, 16'h0001}));
    step();
    keys[2] = 1'b1;
    step();
    step();
    instr_ready = 1'b1;
    step();
    chk("abort_state", 32'({instr_valid, pc, mode, disp_addr}), 0);
    instr_ready = 1'b0;
    keys[2] = 1'b0;
    repeat (4) step();
    iq.delete();

    // wrap boundary
    for (int i = 0; i < 256; i++) begin
      load_word(16'h1000 + 16'(i), 8'(i));
      if (i == 254) chk("pre_wrap", 32'({wrapped, disp_addr}), 32'({1'b0, 8'd255}));
    end
    chk("wrap_set", 32'({wrapped, disp_addr}), 32'({1'b1, 8'd0}));

    instr_ready = 1'b1;
    for (int i = 0; i < 256; i++) iq.push_back(16'h1000 + 16'(i));
    pulse_key(1);
    for (int i = 0; i < 1000 && mode != 2'b10; i++) step();
    chk("full_halt_mode", 32'(mode), 2);
    chk("full_halt_pc", 32'(pc), 255);
    chk("full_q_empty", 32'(iq.size()), 0);
    chk("full_wrapped_kept", 32'(wrapped), 1);
    repeat (5) begin
      step();
      chk("halt_stays", 32'({mode, pc, instr_valid}), 32'({2'b10, 8'd255, 1'b0}));
    end
    instr_ready = 1'b0;
    pulse_key(2);
    chk("halt_to_load", 32'({mode, wrapped, disp_addr}), 0);

    // reset in the middle of a write
    dip = 16'hBEEF;
    wq.push_back({8'd0, 16'hBEEF});
    step();
    keys[0] = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (mem_we) begin
        found = 1'b1;
        break;
      end
    end
    chk("mid_write_seen", 32'(found), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_we", 32'(mem_we), 0);
    chk("rst_async_outs", 32'({mem_addr, mem_din, instr_valid, pc, disp_addr, mode, wrapped}), 0);
    keys = '0;
    step();
    rst_n = 1'b1;
    repeat (3) step();
    chk("post_rst", 32'({mem_we, mode, disp_addr}), 0);
    chk("wq_empty", 32'(wq.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
